mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, which sets the number of bus cycles without an ack before a transaction is aborted.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, which sets the number of consecutive ME grants allowed while IF is pending.
REQ-003 The block SHALL have port iClk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port iRst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port iIF_req, input, 1 bit: instruction-fetch read request, held until oIF_ack.
REQ-006 The block SHALL have port iIF_addr, input, 32 bits: fetch address.
REQ-007 The block SHALL have ports oIF_ack (output, 1 bit), oIF_err (output, 1 bit) and oIF_rdata (output, 32 bits): fetch completion pulse, fetch error pulse and fetch read data.
REQ-008 The block SHALL have port oIF_stall, output, 1 bit: fetch stall request to the hazard unit.
REQ-009 The block SHALL have ports iME_req (input, 1 bit), iME_we (input, 1 bit), iME_be (input, 4 bits), iME_addr (input, 32 bits) and iME_wdata (input, 32 bits): the memory-stage request.
REQ-010 The block SHALL have ports oME_ack (output, 1 bit), oME_err (output, 1 bit), oME_rdata (output, 32 bits) and oME_stall (output, 1 bit): memory-stage response and stall.
REQ-011 The block SHALL have ports oBus_req (output, 1 bit), oBus_we (output, 1 bit), oBus_be (output, 4 bits), oBus_addr (output, 32 bits) and oBus_wdata (output, 32 bits): the shared downstream memory port.
REQ-012 The block SHALL have ports iBus_ack (input, 1 bit), iBus_err (input, 1 bit) and iBus_rdata (input, 32 bits): the downstream response, valid only in the cycle iBus_ack=1.

Function
REQ-013 The FSM SHALL have states IDLE, BUS_IF, BUS_ME and RESP.
REQ-014 In IDLE, with only one request pending, the block SHALL move to BUS_IF or BUS_ME accordingly.
REQ-015 In IDLE, with both requests pending, the block SHALL pick BUS_ME unless starve_cnt==STARVE_MAX, in which case it SHALL pick BUS_IF.
REQ-016 starve_cnt SHALL increment on each ME grant made while iIF_req=1, SHALL saturate at STARVE_MAX, and SHALL clear on any IF grant.
REQ-017 On grant, the block SHALL register address, we, be and wdata, and SHALL hold oBus_* stable with oBus_req=1 for the whole BUS_* state.
REQ-018 IF grants SHALL drive oBus_we=0 and oBus_be=4'hF.
REQ-019 In BUS_*, when iBus_ack=1, the block SHALL latch iBus_rdata into the granted requester's rdata register, latch iBus_err, deassert oBus_req on the next edge and enter RESP.
REQ-020 In RESP, the granted requester's oX_ack SHALL equal 1 for exactly one cycle, oX_err SHALL equal the latched err, and the FSM SHALL then return to IDLE.
REQ-021 The timeout counter SHALL clear on grant and increment each BUS_* cycle without ack.
REQ-022 When the timeout counter reaches TIMEOUT_CYC, the block SHALL abort: enter RESP with err=1 and rdata unchanged, and oBus_req SHALL drop.
REQ-023 iBus_ack in the same cycle as the timeout SHALL win: the response is normal, err=iBus_err.
REQ-024 Minimum latency SHALL be 3 cycles from request sampled in IDLE to the ack pulse: one bus cycle with iBus_ack=1 in the first BUS_* cycle.
REQ-025 Back-to-back transactions from the same requester SHALL be separated by at least one IDLE cycle.
REQ-026 oIF_stall SHALL equal iIF_req & ~oIF_ack, and oME_stall SHALL equal iME_req & ~oME_ack, both combinational.
REQ-027 iBus_ack outside BUS_* SHALL be ignored.
REQ-028 Requester inputs SHALL be ignored except when sampled at grant.
REQ-029 A request withdrawn mid-transaction SHALL still complete on the bus, and its ack SHALL still be issued.
REQ-030 rdata registers SHALL hold their value until the next completion for the same requester.

Reset
REQ-031 While iRst=1, the block SHALL asynchronously force: FSM=IDLE, starve_cnt=0, timeout counter=0, all oBus_* =0, all oX_ack and oX_err =0, and all rdata =32'h0.
REQ-032 Reset asserted mid-transaction SHALL drop oBus_req immediately, SHALL issue no ack, and SHALL discard any later iBus_ack.
REQ-033 The first grant SHALL occur no earlier than the first rising edge after iRst deasserts.

Verification
REQ-034 The bench SHALL cover a single IF read: iIF_req, addr 32'h0000_0100, iBus_ack in the first bus cycle with rdata 32'h0000_0013 -> oBus_addr=32'h100, oBus_we=0, oBus_be=F, oIF_ack pulse on cycle 3 with oIF_rdata=32'h13 and oIF_err=0.
REQ-035 The bench SHALL cover an ME write: we=1, be=4'b0011, addr 32'h2000, wdata 32'hDEAD_BEEF, ack after 2 wait cycles -> bus fields stable for all 3 bus cycles, a single oME_ack, and oME_stall low the cycle after ack.
REQ-036 The bench SHALL cover contention: IF and ME both held continuously -> grant order ME,ME,ME,ME,IF,ME..., with starve_cnt reset after the IF grant.
REQ-037 The bench SHALL cover timeout: TIMEOUT_CYC=8, iBus_ack never asserted -> oBus_req high 8 cycles then low, and oME_ack=1 with oME_err=1 in RESP.
REQ-038 The bench SHALL cover reset mid-transaction: iRst pulsed during BUS_IF, then a late iBus_ack -> no oIF_ack, all outputs 0, and the FSM in IDLE.
REQ-039 The bench SHALL cover ack coinciding with timeout: ack in the same cycle the counter reaches TIMEOUT_CYC with iBus_err=0 -> err=0 and rdata captured.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (IF) and memory stage (ME) share one
// downstream bus. ME has priority, bounded by an IF starvation counter, with a bus timeout.
module mem_arbiter #(
   parameter int TIMEOUT_CYC = 255,
   parameter int STARVE_MAX  = 4
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iIF_req,
   input  logic [31:0] iIF_addr,
   output logic        oIF_ack,
   output logic        oIF_err,
   output logic [31:0] oIF_rdata,
   output logic        oIF_stall,
   input  logic        iME_req,
   input  logic        iME_we,
   input  logic [3:0]  iME_be,
   input  logic [31:0] iME_addr,
   input  logic [31:0] iME_wdata,
   output logic        oME_ack,
   output logic        oME_err,
   output logic [31:0] oME_rdata,
   output logic        oME_stall,
   output logic        oBus_req,
   output logic        oBus_we,
   output logic [3:0]  oBus_be,
   output logic [31:0] oBus_addr,
   output logic [31:0] oBus_wdata,
   input  logic        iBus_ack,
   input  logic        iBus_err,
   input  logic [31:0] iBus_rdata
);
   // state  | meaning
   // IDLE   | no transaction in flight; arbitrate pending requests
   // BUS_IF | fetch on the bus, waiting for ack or timeout
   // BUS_ME | memory-stage access on the bus, waiting for ack or timeout
   // RESP   | one-cycle ack/err pulse to the granted requester
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUS_IF = 2'd1;
   localparam logic [1:0] S_BUS_ME = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   localparam int TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [TW-1:0] TMO_ONE    = TW'(1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [SW-1:0] STARVE_ONE = SW'(1);

   logic [1:0]    state_q, state_d;
   logic          gnt_me_q, gnt_me_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          bus_req_q, bus_req_d;
   logic          bus_we_q, bus_we_d;
   logic [3:0]    bus_be_q, bus_be_d;
   logic [31:0]   bus_addr_q, bus_addr_d;
   logic [31:0]   bus_wdata_q, bus_wdata_d;
   logic          err_q, err_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   me_rdata_q, me_rdata_d;

   always_comb begin
      state_d     = state_q;
      gnt_me_d    = gnt_me_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_be_d    = bus_be_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      err_d       = err_q;
      if_rdata_d  = if_rdata_q;
      me_rdata_d  = me_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (iME_req && (!iIF_req || starve_q != STARVE_LIM)) begin
               state_d     = S_BUS_ME;
               gnt_me_d    = 1'b1;
               tmo_d       = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = iME_we;
               bus_be_d    = iME_be;
               bus_addr_d  = iME_addr;
               bus_wdata_d = iME_wdata;
               if (iIF_req && starve_q != STARVE_LIM) starve_d = starve_q + STARVE_ONE;
            end else if (iIF_req) begin
               state_d     = S_BUS_IF;
               gnt_me_d    = 1'b0;
               tmo_d       = '0;
               starve_d    = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_be_d    = 4'hF;
               bus_addr_d  = iIF_addr;
               bus_wdata_d = 32'h0;
            end
         end
         S_BUS_IF, S_BUS_ME: begin
            // an ack in the timeout cycle wins over the abort
            if (iBus_ack) begin
               state_d   = S_RESP;
               bus_req_d = 1'b0;
               err_d     = iBus_err;
               if (gnt_me_q) me_rdata_d = iBus_rdata;
               else          if_rdata_d = iBus_rdata;
            end else begin
               tmo_d = tmo_q + TMO_ONE;
               if (tmo_q == TMO_LAST) begin
                  state_d   = S_RESP;
                  bus_req_d = 1'b0;
                  err_d     = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q     <= S_IDLE;
         gnt_me_q    <= 1'b0;
         starve_q    <= '0;
         tmo_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_be_q    <= 4'h0;
         bus_addr_q  <= 32'h0;
         bus_wdata_q <= 32'h0;
         err_q       <= 1'b0;
         if_rdata_q  <= 32'h0;
         me_rdata_q  <= 32'h0;
      end else begin
         state_q     <= state_d;
         gnt_me_q    <= gnt_me_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_be_q    <= bus_be_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         err_q       <= err_d;
         if_rdata_q  <= if_rdata_d;
         me_rdata_q  <= me_rdata_d;
      end
   end

   assign oIF_ack    = (state_q == S_RESP) & ~gnt_me_q;
   assign oME_ack    = (state_q == S_RESP) & gnt_me_q;
   assign oIF_err    = oIF_ack & err_q;
   assign oME_err    = oME_ack & err_q;
   assign oIF_rdata  = if_rdata_q;
   assign oME_rdata  = me_rdata_q;
   assign oIF_stall  = iIF_req & ~oIF_ack;
   assign oME_stall  = iME_req & ~oME_ack;
   assign oBus_req   = bus_req_q;
   assign oBus_we    = bus_we_q;
   assign oBus_be    = bus_be_q;
   assign oBus_addr  = bus_addr_q;
   assign oBus_wdata = bus_wdata_q;
endmodule
